// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared defaults, limits and state encoding for the clock divider.
package clk_div_pkg;
   localparam int DIV_W_DEF    = 8;
   localparam int DIV_INIT_DEF = 5;
   localparam int DIV_MIN      = 2;
   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/clk_div_half.sv
// clk_div_half: negedge copy of the posedge phase, ORed in to stretch odd-divisor high time by half a cycle.
module clk_div_half (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic r_n;
   always_ff @(negedge clk)
      if (rst) r_n <= 1'b0;
      else     r_n <= d;
   assign q = d | r_n;
endmodule

// File: rtl/clk_div_n.sv
// clk_div_n: programmable 50%-duty clock divider with glitch-free divisor reload and run/stop control.
module clk_div_n
   import clk_div_pkg::*;
#(
   parameter int DIV_W    = DIV_W_DEF,
   parameter int DIV_INIT = DIV_INIT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [DIV_W-1:0] div,
   input  logic             div_load,
   output logic             clk_out,
   output logic             clk_pulse,
   output logic [DIV_W-1:0] div_cur,
   output logic             div_err
);
   state_t           r_state, w_state_nx;
   logic [DIV_W-1:0] r_cnt, w_cnt_nx, r_div_cur, w_div_nx, r_pend, w_pend_nx;
   logic             r_out_p, w_out_p_nx, r_err, w_ok, w_bad, w_wrap, w_bound, w_half;
   assign w_ok      = div_load && div >= DIV_W'(DIV_MIN);
   assign w_bad     = div_load && div <  DIV_W'(DIV_MIN);
   assign w_pend_nx = w_ok ? div : r_pend;
   assign w_wrap    = r_cnt == r_div_cur - DIV_W'(1);
   // Idle behaves as a boundary every cycle, so loads and en take effect on the next edge.
   assign w_bound   = r_state == IDLE || w_wrap;
   always_ff @(posedge clk)
      if (rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_out_p   <= 1'b0;
         r_div_cur <= DIV_W'(DIV_INIT);
         r_pend    <= DIV_W'(DIV_INIT);
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_cnt     <= w_cnt_nx;
         r_out_p   <= w_out_p_nx;
         r_div_cur <= w_div_nx;
         r_pend    <= w_pend_nx;
         r_err     <= r_err | w_bad;
      end
   always_comb begin
      w_state_nx = w_bound ? (en ? RUN : IDLE) : RUN;
      w_cnt_nx   = w_bound ? '0 : r_cnt + DIV_W'(1);
      w_div_nx   = w_bound ? w_pend_nx : r_div_cur;
   end
   // High for the first floor(D/2) counts; the negedge stretch supplies the extra half cycle when D is odd.
   always_comb begin
      w_out_p_nx = w_state_nx == RUN && w_cnt_nx < (w_div_nx >> 1);
   end
   assign clk_pulse = r_state == RUN && r_cnt == '0;
   assign div_cur   = r_div_cur;
   assign div_err   = r_err;
   clk_div_half u_half (
      .clk (clk),
      .rst (rst),
      .d   (r_out_p),
      .q   (w_half)
   );
   assign clk_out = r_div_cur[0] ? w_half : r_out_p;
endmodule
